column_feeder: RTL and testbench

//  Converts a raster-order pixel stream into one KERNEL_HEIGHT-tall column per accepted pixel,

---
 rtl/cnn_pkg.sv | 16 +
 rtl/line_buffer.sv | 22 ++
 rtl/column_feeder.sv | 135 +++++++++++++
 tb/tb_column_feeder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared conv front-end helpers: column packing order agreed with SlidingWindow,
// plus default frame geometry and the counter widths derived from it.
package cnn_pkg;

  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;
  localparam int COL_CNT_W_DEF  = $clog2(IMG_WIDTH_DEF);
  localparam int ROW_CNT_W_DEF  = $clog2(IMG_HEIGHT_DEF);

  // Flat sample index of filter slot n, channel k, column row j (j=0 oldest row).
  function automatic int col_idx(input int n, input int k, input int j,
                                 input int kh, input int depth);
    return n * (kh * depth) + k * kh + j;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: combinational read, write on the clock when we is high.
// Contents are deliberately not reset.
module line_buffer #(
  parameter int WORDS = 32,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/column_feeder.sv
// Raster pixel stream -> KERNEL_HEIGHT-tall columns for SlidingWindow, with a
// win_valid/coordinate pipeline aligned to SlidingWindow's window_out register.
module column_feeder
  import cnn_pkg::*;
#(
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int DEPTH         = 3,
  parameter int NUM_FILTER    = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [DATA_WIDTH*DEPTH-1:0]                         pix_in,
  input  logic                                                pix_valid,
  input  logic                                                pix_sof,
  output logic                                                pix_ready,
  output logic [DATA_WIDTH*KERNEL_HEIGHT*DEPTH*NUM_FILTER-1:0] col_out,
  output logic                                                col_valid,
  output logic                                                win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0]                       win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                        win_col,
  output logic                                                frame_done
);

  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int PW   = DATA_WIDTH * DEPTH;
  localparam int OW   = PW * KERNEL_HEIGHT * NUM_FILTER;
  localparam int NLB  = KERNEL_HEIGHT - 1;
  localparam int RUNW = $clog2(KERNEL_WIDTH + 1);

  localparam logic [CW-1:0]   LAST_COL  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]   LAST_ROW  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0]   FULL_ROW  = RW'(KERNEL_HEIGHT - 1);
  localparam logic [RUNW-1:0] RUN_MAX   = RUNW'(KERNEL_WIDTH);

  logic [RW-1:0]   row_cnt, cur_row, row_p1;
  logic [CW-1:0]   col_cnt, cur_col, col_p1;
  logic [RUNW-1:0] run_cnt, run_next;
  logic            accept, col_ok, win_hit, win_p1;
  logic [PW-1:0]   lb_rd [NLB];
  logic [PW-1:0]   lb_wr [NLB];
  logic [PW-1:0]   slot  [KERNEL_HEIGHT];
  logic [OW-1:0]   col_next;

  assign accept  = pix_valid & pix_ready;
  assign cur_row = pix_sof ? '0 : row_cnt;
  assign cur_col = pix_sof ? '0 : col_cnt;
  assign col_ok  = accept & (cur_row >= FULL_ROW);

  // Rows ripple down the chain: lb[r] holds the row r+1 above the incoming pixel.
  for (genvar r = 0; r < NLB; r++) begin : g_lb
    if (r == 0) begin : g_head
      assign lb_wr[r] = pix_in;
    end else begin : g_tail
      assign lb_wr[r] = lb_rd[r-1];
    end
    line_buffer #(
      .WORDS (IMG_WIDTH),
      .WIDTH (PW)
    ) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_col),
      .wdata (lb_wr[r]),
      .rdata (lb_rd[r])
    );
    assign slot[KERNEL_HEIGHT-2-r] = lb_rd[r];
  end
  assign slot[KERNEL_HEIGHT-1] = pix_in;

  for (genvar n = 0; n < NUM_FILTER; n++) begin : g_filt
    for (genvar k = 0; k < DEPTH; k++) begin : g_chan
      for (genvar j = 0; j < KERNEL_HEIGHT; j++) begin : g_row
        assign col_next[col_idx(n, k, j, KERNEL_HEIGHT, DEPTH)*DATA_WIDTH +: DATA_WIDTH] =
          slot[j][k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // SlidingWindow shifts every clock, so any cycle without a column breaks the run.
  always_comb begin
    run_next = '0;
    if (col_ok) begin
      if (cur_col == '0)         run_next = RUNW'(1);
      else if (run_cnt == RUN_MAX) run_next = RUN_MAX;
      else                       run_next = run_cnt + RUNW'(1);
    end
  end

  assign win_hit = col_ok & (run_next == RUN_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ready  <= 1'b0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      run_cnt    <= '0;
      col_out    <= '0;
      col_valid  <= 1'b0;
      win_p1     <= 1'b0;
      row_p1     <= '0;
      col_p1     <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_ready  <= 1'b1;
      run_cnt    <= run_next;
      col_valid  <= col_ok;
      win_p1     <= win_hit;
      row_p1     <= win_hit ? cur_row : '0;
      col_p1     <= win_hit ? cur_col : '0;
      win_valid  <= win_p1;
      win_row    <= row_p1;
      win_col    <= col_p1;
      frame_done <= accept & (cur_row == LAST_ROW) & (cur_col == LAST_COL);
      if (accept) begin
        col_out <= col_next;
        if (cur_col == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= (cur_row == LAST_ROW) ? '0 : cur_row + RW'(1);
        end else begin
          col_cnt <= cur_col + CW'(1);
          row_cnt <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_column_feeder.sv
// Directed bench for column_feeder on a 5x4 frame, 3x3 kernel, one channel, two filter slots;
// pixel value = row*16 + col.
module tb_column_feeder;

  localparam int KW  = 3;
  localparam int KH  = 3;
  localparam int DEP = 1;
  localparam int NF  = 2;
  localparam int DW  = 16;
  localparam int IW  = 5;
  localparam int IH  = 4;
  localparam int OW  = DW * KH * DEP * NF;

  localparam logic [OW-1:0] COL_R2C0 = {16'h0020, 16'h0010, 16'h0000,
                                        16'h0020, 16'h0010, 16'h0000};
  localparam logic [OW-1:0] COL_R3C4 = {16'h0034, 16'h0024, 16'h0014,
                                        16'h0034, 16'h0024, 16'h0014};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW*DEP-1:0] pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              pix_ready;
  logic [OW-1:0]     col_out;
  logic              col_valid;
  logic              win_valid;
  logic [1:0]        win_row;
  logic [2:0]        win_col;
  logic              frame_done;

  int checks = 0;
  int failures = 0;

  logic [4:0]    win_log [$];
  logic [4:0]    prev_drv;
  logic          first_cv_seen;
  logic [4:0]    first_cv_rc;
  logic [4:0]    fd_rc;
  logic [OW-1:0] first_cv_out;
  logic [OW-1:0] last_cv_out;
  int            fd_cnt;

  always #5 clk = ~clk;

  column_feeder #(
    .KERNEL_WIDTH  (KW),
    .KERNEL_HEIGHT (KH),
    .DEPTH         (DEP),
    .NUM_FILTER    (NF),
    .DATA_WIDTH    (DW),
    .IMG_WIDTH     (IW),
    .IMG_HEIGHT    (IH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .col_out    (col_out),
    .col_valid  (col_valid),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    win_log.delete();
    prev_drv      = 5'h1F;
    first_cv_seen = 1'b0;
    first_cv_rc   = 5'h1F;
    fd_rc         = 5'h1F;
    first_cv_out  = '0;
    last_cv_out   = '0;
    fd_cnt        = 0;
  endtask

  // One clock: drive (optionally) pixel (r,c), then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input int r, input int c, input logic sof);
    logic [4:0] drv;
    drv       = v ? {2'(r), 3'(c)} : 5'h1F;
    pix_valid = v;
    pix_sof   = sof;
    pix_in    = DW'(r * 16 + c);
    @(posedge clk);
    #1;
    if (win_valid) begin
      win_log.push_back({win_row, win_col});
      chk("win_latency", OW'({win_row, win_col}), OW'(prev_drv));
    end
    if (col_valid) begin
      if (!first_cv_seen) begin
        first_cv_rc   = drv;
        first_cv_out  = col_out;
        first_cv_seen = 1'b1;
      end
      last_cv_out = col_out;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_rc = drv;
    end
    prev_drv  = drv;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic first_sof, input int bub_r, input int bub_c);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == bub_r && c == bub_c) cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b1, r, c, first_sof && r == 0 && c == 0);
      end
    end
    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic chk_frame(input logic bubble);
    logic [4:0] exp_w [$];
    logic [4:0] got;
    exp_w.push_back(5'h12);
    if (!bubble) begin
      exp_w.push_back(5'h13);
      exp_w.push_back(5'h14);
    end
    exp_w.push_back(5'h1A);
    exp_w.push_back(5'h1B);
    exp_w.push_back(5'h1C);
    chk("win_count", OW'(win_log.size()), OW'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      got = (i < win_log.size()) ? win_log[i] : 5'h1F;
      chk("win_pos", OW'(got), OW'(exp_w[i]));
    end
    chk("first_col_pos", OW'(first_cv_rc), OW'(5'h10));
    chk("first_col_out", first_cv_out, COL_R2C0);
    chk("last_col_out", last_cv_out, COL_R3C4);
    chk("frame_done_count", OW'(fd_cnt), OW'(1));
    chk("frame_done_pos", OW'(fd_rc), OW'(5'h1C));
  endtask

  initial begin
    clr_log();

    // Reset held for three cycles
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", OW'(pix_ready), OW'(0));
    chk("rst_col_valid", OW'(col_valid), OW'(0));
    chk("rst_col_out", col_out, OW'(0));
    chk("rst_win_valid", OW'(win_valid), OW'(0));
    chk("rst_win_row", OW'(win_row), OW'(0));
    chk("rst_win_col", OW'(win_col), OW'(0));
    chk("rst_frame_done", OW'(frame_done), OW'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_release", OW'(pix_ready), OW'(1));

    // Contiguous frame with sof
    clr_log();
    send_frame(1'b1, -1, -1);
    chk_frame(1'b0);

    // Next frame without sof, bubble just before (2,3)
    clr_log();
    send_frame(1'b0, 2, 3);
    chk_frame(1'b1);

    // Frame abandoned by sof at (1,2); the restarted frame runs to completion
    clr_log();
    for (int i = 0; i < 7; i++) cyc(1'b1, i / IW, i % IW, i == 0);
    send_frame(1'b1, -1, -1);
    chk_frame(1'b0);

    // Reset one cycle after accepting (2,2)
    clr_log();
    for (int i = 0; i < 13; i++) cyc(1'b1, i / IW, i % IW, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    chk("midrst_pix_ready", OW'(pix_ready), OW'(0));
    chk("midrst_win_valid", OW'(win_valid), OW'(0));
    chk("midrst_col_valid", OW'(col_valid), OW'(0));
    cyc(1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 0, 0, 1'b0);
    chk("midrst_ready_back", OW'(pix_ready), OW'(1));
    chk("midrst_no_window", OW'(win_log.size()), OW'(0));
    clr_log();
    send_frame(1'b0, -1, -1);
    chk_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
